// File: rtl/ch7301_cfg_ctrl.sv
// ch7301_cfg_ctrl: CH7301 power-up sequencer and I2C master that writes a fixed register table
module ch7301_cfg_ctrl #(
  parameter int         CLK_DIV     = 250,
  parameter logic [6:0] DEV_ADDR    = 7'h76,
  parameter int         RST_CYCLES  = 100000,
  parameter int         WAIT_CYCLES = 1000000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       sda_i,
  output logic       scl,
  output logic       sda_oe,
  output logic       ch_rstn,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [2:0] err_index
);
  typedef enum logic [2:0] {RST_LOW, RST_WAIT, START, BYTE, ACK, STOP, GAP, FINISH} state_t;
  localparam logic [7:0] REG_T [8] = '{8'h1C, 8'h1D, 8'h1F, 8'h21, 8'h33, 8'h34, 8'h36, 8'h49};
  localparam logic [7:0] DAT_T [8] = '{8'h04, 8'h45, 8'h80, 8'h09, 8'h08, 8'h16, 8'h60, 8'hC0};
  state_t      state, state_nx;
  logic [31:0] cnt;
  logic [1:0]  q, byte_cnt;
  logic [2:0]  bit_cnt, idx;
  logic [7:0]  retry, cur_byte;
  logic        nack, s1, s2, i2c, tick, ph_end, bit_val;
  assign i2c      = state inside {START, BYTE, ACK, STOP, GAP};
  assign tick     = i2c && cnt == CLK_DIV - 1;
  assign ph_end   = tick && q == 2'd3;
  assign cur_byte = byte_cnt == 2'd0 ? {DEV_ADDR, 1'b0} : byte_cnt == 2'd1 ? REG_T[idx] : DAT_T[idx];
  assign bit_val  = cur_byte[3'd7 - bit_cnt];
  assign ch_rstn  = state != RST_LOW;
  assign busy     = state != FINISH;
  assign done     = state == FINISH;
  // state register
  always_ff @(posedge sys_clk) state <= sys_rst ? RST_LOW : state_nx;
  // next state and bus drive, one quarter-bit pattern per phase
  always_comb begin
    state_nx = state;
    scl      = 1'b1;
    sda_oe   = 1'b0;
    case (state)
      RST_LOW:  if (cnt == RST_CYCLES - 1) state_nx = RST_WAIT;
      RST_WAIT: if (cnt == WAIT_CYCLES - 1) state_nx = START;
      START: begin
        scl    = !q[1];
        sda_oe = q != 2'd0;
        if (ph_end) state_nx = BYTE;
      end
      BYTE: begin
        scl    = q[1];
        sda_oe = !bit_val;
        if (ph_end && bit_cnt == 3'd7) state_nx = ACK;
      end
      ACK: begin
        scl = q[1];
        if (ph_end) state_nx = (nack || byte_cnt == 2'd2) ? STOP : BYTE;
      end
      STOP: begin
        scl    = q != 2'd0;
        sda_oe = !q[1];
        if (ph_end) state_nx = GAP;
      end
      GAP:    if (ph_end) state_nx = (nack ? retry >= 8'(MAX_RETRY) : idx == 3'd7) ? FINISH : START;
      FINISH: if (start) state_nx = START;
    endcase
  end
  // two-flop synchroniser on the SDA read-back
  always_ff @(posedge sys_clk) begin
    s1 <= sys_rst | sda_i;
    s2 <= sys_rst | s1;
  end
  // timing counters, byte/bit position, ACK capture, retry and error bookkeeping
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt       <= '0;
      q         <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      idx       <= '0;
      retry     <= '0;
      nack      <= 1'b0;
      ack_err   <= 1'b0;
      err_index <= '0;
    end else begin
      cnt <= (state_nx != state || tick || state == FINISH) ? '0 : cnt + 32'd1;
      q   <= q + {1'b0, tick};
      if (state == START) byte_cnt <= '0;
      if (state == BYTE && ph_end) bit_cnt <= bit_cnt + 3'd1;
      if (state == ACK && tick && q == 2'd2) nack <= s2;
      if (state == ACK && ph_end) byte_cnt <= byte_cnt + 2'd1;
      if (state == GAP && ph_end) begin
        idx   <= nack ? idx : idx + 3'd1;
        retry <= (nack && retry < 8'(MAX_RETRY)) ? retry + 8'd1 : '0;
        if (nack && retry >= 8'(MAX_RETRY)) begin
          ack_err   <= 1'b1;
          err_index <= idx;
        end
      end
      if (state == FINISH && start) begin
        ack_err   <= 1'b0;
        err_index <= '0;
        idx       <= '0;
        retry     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ch7301_cfg_ctrl.sv
// tb_ch7301_cfg_ctrl: directed bench with a bus-level I2C slave model for ch7301_cfg_ctrl
module tb_ch7301_cfg_ctrl;
  logic sys_clk = 1'b0, sys_rst = 1'b1, start = 1'b0, s_pull = 1'b0;
  logic sda_i, scl, sda_oe, ch_rstn, busy, done, ack_err;
  logic [2:0] err_index;
  int n_chk = 0, n_fail = 0;
  int mode = 0, tx_num = 0, proto_err = 0, rstn_low = 0;
  int bitn = 0, bytn = 0, nb = 0;
  logic in_tx = 1'b0, acking = 1'b0, p_scl = 1'b1, p_line = 1'b1, line_v, nk;
  logic [7:0] cur = '0;
  logic [7:0] tb_b [3];
  logic [31:0] log_q [$];
  logic [7:0] reg_e [8] = '{8'h1C, 8'h1D, 8'h1F, 8'h21, 8'h33, 8'h34, 8'h36, 8'h49};
  logic [7:0] dat_e [8] = '{8'h04, 8'h45, 8'h80, 8'h09, 8'h08, 8'h16, 8'h60, 8'hC0};
  assign sda_i = ~(sda_oe | s_pull);
  always #5 sys_clk = ~sys_clk;
  ch7301_cfg_ctrl #(.CLK_DIV(2), .DEV_ADDR(7'h76), .RST_CYCLES(4), .WAIT_CYCLES(8), .MAX_RETRY(3)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .sda_i(sda_i), .scl(scl), .sda_oe(sda_oe),
    .ch_rstn(ch_rstn), .busy(busy), .done(done), .ack_err(ack_err), .err_index(err_index)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_done(input int lim, output int k);
    k = 0;
    while (!done && k < lim) begin
      @(negedge sys_clk);
      k++;
    end
    check("done_reached", k < lim, 1);
  endtask
  task automatic pulse_start;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask
  // I2C slave: decodes START/STOP/bits, ACKs per mode, logs each transaction, flags misplaced START/STOP
  always @(negedge sys_clk) begin
    line_v = ~(sda_oe | s_pull);
    if (!ch_rstn) rstn_low++;
    if (sys_rst) begin
      in_tx = 0; acking = 0; bitn = 0; bytn = 0; s_pull = 0;
    end else if (scl && p_scl && p_line && !line_v) begin
      if (in_tx) proto_err++;
      in_tx = 1; bitn = 0; bytn = 0; nb = 0;
      tb_b[0] = '0; tb_b[1] = '0; tb_b[2] = '0;
    end else if (scl && p_scl && !p_line && line_v) begin
      if (!in_tx || bitn > 1 || acking) proto_err++;
      log_q.push_back({8'(nb), tb_b[0], tb_b[1], tb_b[2]});
      in_tx = 0;
      tx_num++;
    end else if (in_tx && scl && !p_scl && bitn < 8) begin
      cur = {cur[6:0], line_v};
      bitn++;
    end else if (in_tx && !scl && p_scl) begin
      if (acking) begin
        s_pull = 0; acking = 0; bitn = 0; bytn++;
      end else if (bitn == 8 && bytn < 3) begin
        tb_b[bytn] = cur;
        nb++;
        nk = (mode == 1 && bytn == 0 && (tx_num == 3 || tx_num == 4)) ||
             (mode == 2 && bytn == 2 && tb_b[1] == 8'h34);
        s_pull = !nk;
        acking = 1;
      end
    end
    p_scl  = scl;
    p_line = line_v;
  end
  initial begin
    int n, m, k, r0;
    logic [31:0] e;
    repeat (3) @(negedge sys_clk);
    check("rst_scl", scl, 1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_ch_rstn", ch_rstn, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_err_index", err_index, 0);
    sys_rst = 1'b0;
    n = 0;
    while (!ch_rstn && n < 100) begin n++; @(negedge sys_clk); end
    check("rstn_low_cycles", n, 4);
    m = 0;
    while (!(scl && sda_oe) && m < 100) begin m++; @(negedge sys_clk); end
    check("rstn_to_start_fall", m, 10);
    wait_done(5000, k);
    check("run1_cycles", k, 1918);
    check("run1_busy", busy, 0);
    check("run1_ack_err", ack_err, 0);
    check("run1_count", log_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("run1_tx%0d", i), log_q[i], {8'd3, 8'hEC, reg_e[i], dat_e[i]});
    log_q.delete(); tx_num = 0; mode = 1; r0 = rstn_low;
    pulse_start();
    check("restart_done_low", done, 0);
    check("restart_busy", busy, 1);
    check("restart_ch_rstn", ch_rstn, 1);
    repeat (300) @(negedge sys_clk);
    pulse_start();
    wait_done(5000, k);
    check("run2_cycles", k + 301, 2112);
    check("run2_no_chip_reset", rstn_low - r0, 0);
    check("run2_ack_err", ack_err, 0);
    check("run2_count", log_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      e = (i == 3 || i == 4) ? {8'd1, 8'hEC, 16'h0} :
          {8'd3, 8'hEC, reg_e[i < 3 ? i : i - 2], dat_e[i < 3 ? i : i - 2]};
      check($sformatf("run2_tx%0d", i), log_q[i], e);
    end
    log_q.delete(); tx_num = 0; mode = 2;
    pulse_start();
    wait_done(5000, k);
    check("run3_ack_err", ack_err, 1);
    check("run3_err_index", err_index, 5);
    check("run3_busy", busy, 0);
    check("run3_count", log_q.size(), 9);
    for (int i = 5; i < 9; i++) check($sformatf("run3_tx%0d", i), log_q[i], {8'd3, 8'hEC, 8'h34, 8'h16});
    log_q.delete(); tx_num = 0; mode = 0;
    pulse_start();
    check("restart_clears_ack_err", ack_err, 0);
    check("restart_clears_err_index", err_index, 0);
    k = 0;
    while (!(log_q.size() == 2 && bytn == 1 && bitn == 4) && k < 5000) begin k++; @(negedge sys_clk); end
    check("reach_entry2_reg_bit4", k < 5000, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_scl", scl, 1);
    check("midrst_sda_oe", sda_oe, 0);
    check("midrst_ch_rstn", ch_rstn, 0);
    check("midrst_busy", busy, 1);
    check("midrst_done", done, 0);
    @(negedge sys_clk);
    log_q.delete(); tx_num = 0;
    sys_rst = 1'b0;
    n = 0;
    while (!ch_rstn && n < 100) begin n++; @(negedge sys_clk); end
    check("midrst_rstn_low_cycles", n, 4);
    wait_done(5000, k);
    check("run4_ack_err", ack_err, 0);
    check("run4_count", log_q.size(), 8);
    check("run4_tx0", log_q[0], {8'd3, 8'hEC, 8'h1C, 8'h04});
    check("run4_tx2", log_q[2], {8'd3, 8'hEC, 8'h1F, 8'h80});
    check("run4_tx7", log_q[7], {8'd3, 8'hEC, 8'h49, 8'hC0});
    check("protocol_errors", proto_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
